// File: rtl/lsu_arb_pkg.sv
// Shared types, region constants and access helpers for the LSU arbiter.
package lsu_arb_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WAIT = 2'b10
  } state_e;

  localparam logic [11:0] IO_BASE  = 12'h400;
  localparam logic [11:0] SW_BASE  = 12'h500;
  localparam logic [11:0] RSV_BASE = 12'h600;

  function automatic logic size_err(logic [1:0] size, logic [11:0] addr);
    return (size == SZ_ILL) ||
           ((size == SZ_H) && addr[0]) ||
           ((size == SZ_W) && (addr[1:0] != 2'b00));
  endfunction

  // LSU data arrives zero-masked, so only the signed cases need work.
  function automatic logic [31:0] ld_extend(logic [31:0] d, logic is_b, logic is_h, logic uns);
    logic [31:0] r;
    r = d;
    if (!uns && is_b)      r = {{24{d[7]}}, d[7:0]};
    else if (!uns && is_h) r = {{16{d[15]}}, d[15:0]};
    return r;
  endfunction

endpackage

// File: rtl/lsu_arbiter_rr_arbiter.sv
// N-way one-hot grant; rotating priority pointer when RR_EN, else lowest index wins.
module rr_arbiter #(
  parameter int N     = 2,
  parameter bit RR_EN = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N-1:0]         req_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] j;
  logic          found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    j         = '0;
    for (int i = 0; i < N; i++) begin
      j = RR_EN ? IW'((int'(ptr_q) + i) % N) : IW'(i);
      if (!found && req_i[j]) begin
        found     = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = j;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= (int'(gnt_idx_o) == N - 1) ? '0 : gnt_idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/lsu_arbiter.sv
// Shares one LSU between N_REQ requesters: registers one request, sequences the
// LSU controls over 1-2 cycles and returns one registered response pulse.
//   state | meaning
//   IDLE  | ready to accept; response pulse of previous access may be out
//   EXEC  | address issued; store enable for legal stores
//   WAIT  | load data returning from LSU, captured at end of cycle
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter bit RR_EN = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N_REQ-1:0]      req_valid_i,
  output logic [N_REQ-1:0]      req_ready_o,
  input  logic [N_REQ-1:0]      req_we_i,
  input  logic [2*N_REQ-1:0]    req_size_i,
  input  logic [N_REQ-1:0]      req_uns_i,
  input  logic [12*N_REQ-1:0]   req_addr_i,
  input  logic [32*N_REQ-1:0]   req_wdata_i,
  output logic [N_REQ-1:0]      rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  lsu_st_en_o,
  output logic                  lsu_ld_byte_o,
  output logic                  lsu_ld_halfword_o,
  output logic [11:0]           lsu_addr_o,
  output logic [31:0]           lsu_st_data_o,
  input  logic [31:0]           lsu_ld_data_i
);

  localparam int IW = $clog2(N_REQ);

  state_e state_q, state_d;
  logic [N_REQ-1:0] arb_req, gnt;
  logic [IW-1:0]    gnt_idx;
  logic             hs, rsp_load;

  logic        sel_we, sel_uns;
  logic [1:0]  sel_size;
  logic [11:0] sel_addr;
  logic [31:0] sel_wdata;

  logic          we_q, byte_q, half_q, uns_q, err_q;
  logic [11:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [IW-1:0] idx_q;

  logic [N_REQ-1:0] rsp_valid_q;
  logic [31:0]      rsp_rdata_q;
  logic             rsp_err_q;

  assign arb_req = (state_q == IDLE) ? req_valid_i : '0;

  rr_arbiter #(.N(N_REQ), .RR_EN(RR_EN)) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (arb_req),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign req_ready_o = gnt;
  assign hs          = |gnt;

  always_comb begin
    sel_we    = 1'b0;
    sel_uns   = 1'b0;
    sel_size  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_we    = req_we_i[i];
        sel_uns   = req_uns_i[i];
        sel_size  = req_size_i[2*i +: 2];
        sel_addr  = req_addr_i[12*i +: 12];
        sel_wdata = req_wdata_i[32*i +: 32];
      end
    end
  end

  // Size is held pre-decoded so the LSU qualifiers read 0 out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      half_q  <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
    end else if (hs) begin
      we_q    <= sel_we;
      byte_q  <= (sel_size == SZ_B);
      half_q  <= (sel_size == SZ_H);
      uns_q   <= sel_uns;
      err_q   <= size_err(sel_size, sel_addr);
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
      idx_q   <= gnt_idx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    rsp_load = 1'b0;
    case (state_q)
      IDLE: if (hs) state_d = EXEC;
      EXEC: begin
        if (we_q || err_q) begin
          state_d  = IDLE;
          rsp_load = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d  = IDLE;
        rsp_load = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      if (rsp_load) begin
        rsp_valid_q <= N_REQ'(1) << idx_q;
        rsp_rdata_q <= (state_q == WAIT) ? ld_extend(lsu_ld_data_i, byte_q, half_q, uns_q) : '0;
        rsp_err_q   <= err_q;
      end
    end
  end

  // Decoded from the state register so reset drops it asynchronously.
  assign lsu_st_en_o       = (state_q == EXEC) && we_q && !err_q;
  assign lsu_ld_byte_o     = byte_q;
  assign lsu_ld_halfword_o = half_q;
  assign lsu_addr_o        = addr_q;
  assign lsu_st_data_o     = wdata_q;

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Self-checking bench: directed + random accesses against a behavioural LSU/arbiter model.
module tb_lsu_arbiter;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fp_mode = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    valid = '0;
  logic [N-1:0]    we = '0;
  logic [N-1:0]    uns = '0;
  logic [2*N-1:0]  size = '0;
  logic [12*N-1:0] addr = '0;
  logic [32*N-1:0] wdata = '0;
  logic [31:0]     ld_data;

  logic [N-1:0] ready, rsp_valid, ready_f, rsp_valid_f;
  logic [31:0]  rdata, rdata_f, lsd, lsd_f;
  logic [11:0]  laddr, laddr_f;
  logic         err, err_f, st_en, st_en_f, lb, lb_f, lh, lh_f;

  lsu_arbiter #(.N_REQ(N), .RR_EN(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(fp_mode ? '0 : valid), .req_ready_o(ready),
    .req_we_i(we), .req_size_i(size), .req_uns_i(uns), .req_addr_i(addr), .req_wdata_i(wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rdata), .rsp_err_o(err),
    .lsu_st_en_o(st_en), .lsu_ld_byte_o(lb), .lsu_ld_halfword_o(lh),
    .lsu_addr_o(laddr), .lsu_st_data_o(lsd), .lsu_ld_data_i(ld_data)
  );

  lsu_arbiter #(.N_REQ(N), .RR_EN(1'b0)) dut_f (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(fp_mode ? valid : '0), .req_ready_o(ready_f),
    .req_we_i(we), .req_size_i(size), .req_uns_i(uns), .req_addr_i(addr), .req_wdata_i(wdata),
    .rsp_valid_o(rsp_valid_f), .rsp_rdata_o(rdata_f), .rsp_err_o(err_f),
    .lsu_st_en_o(st_en_f), .lsu_ld_byte_o(lb_f), .lsu_ld_halfword_o(lh_f),
    .lsu_addr_o(laddr_f), .lsu_st_data_o(lsd_f), .lsu_ld_data_i(ld_data)
  );

  // LSU model: one word per byte address, zero-masked reads, shared by whichever DUT is active.
  function automatic logic [31:0] init_val(logic [11:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'hA5A5_5A5A;
  endfunction

  logic [31:0] lsu_mem [4096];
  bit          lsu_wr  [4096];
  logic        m_st_en, m_lb, m_lh;
  logic [11:0] m_addr;
  logic [31:0] m_sd, ld_raw;

  assign m_st_en = fp_mode ? st_en_f : st_en;
  assign m_lb    = fp_mode ? lb_f : lb;
  assign m_lh    = fp_mode ? lh_f : lh;
  assign m_addr  = fp_mode ? laddr_f : laddr;
  assign m_sd    = fp_mode ? lsd_f : lsd;
  assign ld_raw  = lsu_wr[m_addr] ? lsu_mem[m_addr] : init_val(m_addr);
  assign ld_data = m_lb ? {24'h0, ld_raw[7:0]} : m_lh ? {16'h0, ld_raw[15:0]} : ld_raw;

  always @(posedge clk) begin
    if (m_st_en) begin
      lsu_mem[m_addr] <= m_sd;
      lsu_wr[m_addr]  <= 1'b1;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [int];
  int rr_ptr = 0;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic bit legal_err(bit [1:0] sz, bit [11:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] model_rdata(bit w, bit [1:0] sz, bit u, bit [11:0] a);
    logic [31:0] d;
    if (w || legal_err(sz, a)) return 32'h0;
    d = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    if (sz == 2'd0) begin
      d = d % 256;
      if (!u && d >= 128) d = d + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      d = d % 65536;
      if (!u && d >= 32768) d = d + 32'hFFFF_0000;
    end
    return d;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(int p, bit w, bit [1:0] sz, bit u, bit [11:0] a, bit [31:0] d);
    we[p] = w; uns[p] = u; size[2*p +: 2] = sz; addr[12*p +: 12] = a; wdata[32*p +: 32] = d;
  endtask

  task automatic wait_ready(int p);
    int k = 0;
    while (ready[p] !== 1'b1 && k < 20) begin @(negedge clk); k++; end
  endtask

  // Single-requester access on the RR instance, checked cycle by cycle.
  task automatic txn(int p, bit w, bit [1:0] sz, bit u, bit [11:0] a, bit [31:0] d);
    bit e;
    logic [31:0] exp_rd;
    @(negedge clk);
    drive(p, w, sz, u, a, d);
    valid[p] = 1'b1;
    wait_ready(p);
    chk("grant", 32'(ready), 32'(1 << p));
    e = legal_err(sz, a);
    exp_rd = model_rdata(w, sz, u, a);
    rr_ptr = (p + 1) % N;
    @(negedge clk);
    valid[p] = 1'b0;
    chk("exec_st_en", 32'(st_en), 32'(w && !e));
    chk("exec_addr", 32'(laddr), 32'(a));
    chk("exec_byte", 32'(lb), 32'(sz == 2'd0));
    chk("exec_half", 32'(lh), 32'(sz == 2'd1));
    if (w) chk("exec_st_data", lsd, d);
    chk("exec_no_rsp", 32'(rsp_valid), 32'h0);
    if (!w && !e) begin
      @(negedge clk);
      chk("wait_st_en", 32'(st_en), 32'h0);
      chk("wait_addr", 32'(laddr), 32'(a));
      chk("wait_no_rsp", 32'(rsp_valid), 32'h0);
    end
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'(1 << p));
    chk("rsp_rdata", rdata, exp_rd);
    chk("rsp_err", 32'(err), 32'(e));
    if (w && !e) ref_mem[int'(a)] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    // Reset state
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_st_en", 32'(st_en), 32'h0);
    chk("rst_byte", 32'(lb), 32'h0);
    chk("rst_half", 32'(lh), 32'h0);
    chk("rst_addr", 32'(laddr), 32'h0);
    chk("rst_st_data", lsd, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    valid[0] = 1'b1;
    #1 chk("comb_ready", 32'(ready), 32'h1);
    valid[0] = 1'b0;
    #1 chk("drop_ready", 32'(ready), 32'h0);
    @(negedge clk);
    chk("drop_no_exec", 32'(st_en), 32'h0);
    chk("drop_no_rsp", 32'(rsp_valid), 32'h0);

    // Directed accesses
    txn(0, 1'b1, 2'd2, 1'b0, 12'h010, 32'hDEAD_BEEF);
    txn(1, 1'b0, 2'd0, 1'b0, 12'h010, 32'h0);
    txn(1, 1'b0, 2'd0, 1'b1, 12'h010, 32'h0);
    txn(0, 1'b0, 2'd1, 1'b0, 12'h012, 32'h0);
    txn(0, 1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
    txn(1, 1'b0, 2'd1, 1'b0, 12'h011, 32'h0);
    txn(0, 1'b1, 2'd3, 1'b0, 12'h020, 32'h1234_5678);
    txn(0, 1'b1, 2'd2, 1'b0, 12'h016, 32'h0BAD_F00D);
    txn(1, 1'b1, 2'd1, 1'b0, 12'h450, 32'h0000_8001);
    txn(1, 1'b0, 2'd1, 1'b0, 12'h450, 32'h0);
    txn(0, 1'b0, 2'd1, 1'b1, 12'h7FE, 32'h0);

    // Random accesses
    for (int i = 0; i < 40; i++) begin
      bit [11:0] a;
      a = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), a, $urandom);
    end

    // Round-robin with both requesters continuously valid
    @(negedge clk);
    drive(0, 1'b1, 2'd2, 1'b0, 12'h100, 32'hAAAA_0001);
    drive(1, 1'b1, 2'd2, 1'b0, 12'h104, 32'hBBBB_0002);
    valid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      wait_ready(0 + (ready[1] === 1'b1 ? 1 : 0));
      chk("rr_grant", 32'(ready), 32'(1 << rr_ptr));
      g = rr_ptr;
      rr_ptr = (g + 1) % N;
      @(negedge clk);
      @(negedge clk);
      chk("rr_rsp", 32'(rsp_valid), 32'(1 << g));
    end
    valid = 2'b00;
    ref_mem[int'(12'h100)] = 32'hAAAA_0001;
    ref_mem[int'(12'h104)] = 32'hBBBB_0002;

    // Fixed priority instance
    @(negedge clk);
    fp_mode = 1'b1;
    @(negedge clk);
    valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 chk("fp_grant", 32'(ready_f), 32'h1);
      @(negedge clk);
      @(negedge clk);
      chk("fp_rsp", 32'(rsp_valid_f), 32'h1);
    end
    valid = 2'b10;
    #1 chk("fp_grant_p1", 32'(ready_f), 32'h2);
    @(negedge clk);
    valid = 2'b00;
    @(negedge clk);
    chk("fp_rsp_p1", 32'(rsp_valid_f), 32'h2);
    @(negedge clk);
    fp_mode = 1'b0;

    // Reset while a store is in EXEC: store enable must drop at once
    @(negedge clk);
    drive(0, 1'b1, 2'd2, 1'b0, 12'h200, 32'hCAFE_0000);
    valid[0] = 1'b1;
    wait_ready(0);
    @(negedge clk);
    valid[0] = 1'b0;
    chk("pre_rst_st_en", 32'(st_en), 32'h1);
    rst_n = 1'b0;
    #1 chk("async_st_en", 32'(st_en), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rr_ptr = 0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_st_no_rsp", 32'(rsp_valid), 32'h0);
    end

    // Reset while a load is in WAIT
    drive(1, 1'b0, 2'd2, 1'b0, 12'h104, 32'h0);
    valid[1] = 1'b1;
    wait_ready(1);
    @(negedge clk);
    valid[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("wait_rst_st_en", 32'(st_en), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rr_ptr = 0;
    chk("wait_rst_addr", 32'(laddr), 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_ld_no_rsp", 32'(rsp_valid), 32'h0);
    end
    txn(1, 1'b0, 2'd2, 1'b0, 12'h104, 32'h0);
    txn(0, 1'b1, 2'd0, 1'b0, 12'h5FF, 32'h0000_0080);
    txn(1, 1'b0, 2'd0, 1'b0, 12'h5FF, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
